oa_pipe_array: RTL

OA_PIPE_ARRAY -- requirements
Module: oa_pipe_array

---
 rtl/oa_pipe_array_pkg.sv | 24 ++
 rtl/oa_or_group.sv | 13 +
 rtl/oa_pipe_array.sv | 97 +++++++++
 3 files changed

// File: rtl/oa_pipe_array_pkg.sv
// Shared definitions for the OA/OAI pipeline array: MODE encodings,
// legal parameter ranges, and the operand bit-index helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package oa_pipe_array_pkg;

  typedef enum logic {
    MODE_OA  = 1'b0,  // AND of ORs
    MODE_OAI = 1'b1   // inverted AND of ORs
  } mode_e;

  localparam int CH_MIN     = 1;
  localparam int CH_MAX     = 32;
  localparam int GROUPS_MIN = 1;
  localparam int GROUPS_MAX = 8;
  localparam int GW_MIN     = 1;
  localparam int GW_MAX     = 8;

  // Flat operand index of input i of group g in channel ch.
  function automatic int in_idx(input int ch, input int g, input int i,
                                input int groups, input int gw);
    return ch * groups * gw + g * gw + i;
  endfunction

endpackage

// File: rtl/oa_or_group.sv
// GW-input OR reduction for one group of one channel.
// Latency: combinational, 0 cycles. Backpressure: none (pure logic).
// Ports: bits = group operands, y = OR of all operands.
module oa_or_group #(
  parameter int GW = 2
) (
  input  logic [GW-1:0] bits,
  output logic          y
);

  assign y = |bits;

endmodule

// File: rtl/oa_pipe_array.sv
// Two-stage OA/OAI array: stage 1 registers group ORs + mode, stage 2 the result.
// Latency: accept edge -> stage 1, next edge -> Q_VALID; one beat per cycle sustained.
// Backpressure: q_ready low holds Q; stage 1 still fills, then in_ready drops.
// Ports: in/mode/in_valid/in_ready = operand beat, q/q_valid/q_ready = result,
//        q_chg = per-channel difference from the last delivered result.
module oa_pipe_array
  import oa_pipe_array_pkg::*;
#(
  parameter int CH     = 4,
  parameter int GROUPS = 3,
  parameter int GW     = 2
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic [CH*GROUPS*GW-1:0] in,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [CH-1:0]          q,
  output logic                   q_valid,
  input  logic                   q_ready,
  output logic [CH-1:0]          q_chg
);

  if (CH < CH_MIN || CH > CH_MAX || GROUPS < GROUPS_MIN || GROUPS > GROUPS_MAX ||
      GW < GW_MIN || GW > GW_MAX) begin : g_param_err
    $error("oa_pipe_array: CH/GROUPS/GW outside supported range");
  end

  logic [CH*GROUPS-1:0] or_w;
  logic [CH*GROUPS-1:0] s1_or;
  mode_e                s1_mode;
  logic                 s1_vld;
  logic [CH-1:0]        res;
  logic [CH-1:0]        last_q;
  logic                 s2_load;
  logic                 accept;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
      oa_or_group #(.GW(GW)) u_or (
        .bits (in[in_idx(c, g, 0, GROUPS, GW) +: GW]),
        .y    (or_w[c*GROUPS + g])
      );
    end
  end

  // Stage 2 may take stage 1 when it is empty or is being emptied this edge.
  assign s2_load  = s1_vld && (!q_valid || q_ready);
  // Stage 1 is free if empty or moving forward; never depends on in_valid.
  assign in_ready = !s1_vld || s2_load;
  assign accept   = in_valid && in_ready;

  always_comb begin
    res = '0;
    for (int c = 0; c < CH; c++) begin
      res[c] = (&s1_or[c*GROUPS +: GROUPS]) ^ (s1_mode == MODE_OAI);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_vld  <= 1'b0;
      s1_or   <= '0;
      s1_mode <= MODE_OA;
    end else if (accept) begin
      s1_vld  <= 1'b1;
      s1_or   <= or_w;
      s1_mode <= mode_e'(mode);
    end else if (s2_load) begin
      s1_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else if (s2_load) begin
      q_valid <= 1'b1;
      q       <= res;
    end else if (q_ready) begin
      q_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      last_q <= '0;
    end else if (q_valid && q_ready) begin
      last_q <= q;
    end
  end

  assign q_chg = q_valid ? (q ^ last_q) : '0;

endmodule
